// File: rtl/stack_unit_pkg.sv
// Shared constants, operation encoding and sizing helper for the stack unit.
package stack_unit_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 16;

    // Operation decode of {push, pop}
    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } op_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/stack_unit_ram.sv
// Stack storage: one write port and one combinational read port, contents not reset.
module stack_ram
    import stack_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with registered top/next views, occupancy count and sticky error flags.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top,
    output logic [DATA_W-1:0] next,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [DATA_W-1:0] r_top;
    logic [DATA_W-1:0] r_next;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    op_e               w_op;
    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [AW-1:0]     w_raddr;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_top_d;
    logic [DATA_W-1:0] w_next_d;
    logic [CNT_W-1:0]  w_count_d;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_ovf_d;
    logic              w_unf_d;

    assign w_op    = op_e'({push, pop});
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // The read port only ever serves a pop: it fetches the entry that becomes the new next.
    assign w_raddr = AW'(r_count - CNT_W'(3));

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (push_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_we      = 1'b0;
        w_waddr   = AW'(r_count);
        w_count_d = r_count;
        w_top_d   = r_top;
        w_next_d  = r_next;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (w_op)
            OpPush: begin
                if (!w_full) begin
                    w_we      = 1'b1;
                    w_count_d = r_count + CNT_W'(1);
                    w_top_d   = push_data;
                    w_next_d  = r_top;
                end else begin
                    w_ovf_set = 1'b1;
                end
            end
            OpPop: begin
                if (!w_empty) begin
                    w_count_d = r_count - CNT_W'(1);
                    w_top_d   = r_next;
                    w_next_d  = (r_count >= CNT_W'(3)) ? w_rdata : '0;
                end else begin
                    w_unf_set = 1'b1;
                end
            end
            OpBoth: begin
                w_we    = 1'b1;
                w_top_d = push_data;
                if (w_empty) begin
                    w_count_d = r_count + CNT_W'(1);
                    w_next_d  = r_top;
                end else begin
                    // Replace the top entry in place
                    w_waddr = AW'(r_count - CNT_W'(1));
                end
            end
            default: ;
        endcase
    end

    // A new error outranks a simultaneous clear
    assign w_ovf_d = w_ovf_set | (r_ovf & ~err_clr);
    assign w_unf_d = w_unf_set | (r_unf & ~err_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_top   <= '0;
            r_next  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_top   <= w_top_d;
            r_next  <= w_next_d;
            r_count <= w_count_d;
            r_ovf   <= w_ovf_d;
            r_unf   <= w_unf_d;
        end
    end

    assign top       = r_top;
    assign next      = r_next;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit with a queue-based reference model checked every cycle.
module tb_stack_unit;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [31:0] push_data = '0;
    logic        err_clr = 1'b0;
    logic [31:0] top;
    logic [31:0] next;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int failures = 0;

    // Reference model: the stack as a queue, back = top of stack
    logic [31:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    stack_unit #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .err_clr   (err_clr),
        .top       (top),
        .next      (next),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_top();
        return (m_q.size() > 0) ? m_q[m_q.size()-1] : 32'h0;
    endfunction

    function automatic logic [31:0] m_next();
        return (m_q.size() > 1) ? m_q[m_q.size()-2] : 32'h0;
    endfunction

    task automatic model_step(input logic p, input logic o, input logic [31:0] d, input logic c);
        logic e_o;
        logic e_u;
        int   n;
        n   = m_q.size();
        e_o = p && !o && (n == DEPTH);
        e_u = o && !p && (n == 0);
        if (p && o && n > 0) m_q[n-1] = d;
        else if (p && n < DEPTH) m_q.push_back(d);
        else if (o && !p && n > 0) void'(m_q.pop_back());
        m_ovf = e_o ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = e_u ? 1'b1 : (c ? 1'b0 : m_unf);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("cmp_top", top, m_top());
        chk("cmp_next", next, m_next());
        chk("cmp_count", 32'(count), 32'(m_q.size()));
        chk("cmp_empty", 32'(empty), 32'(m_q.size() == 0));
        chk("cmp_full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
        chk("cmp_underflow", 32'(underflow), 32'(m_unf));
    end

    // Drive one operation for one edge; returns 2 time units after that edge
    task automatic op(input logic p, input logic o, input logic [31:0] d, input logic c);
        push      = p;
        pop       = o;
        push_data = d;
        err_clr   = c;
        @(posedge clk);
        model_step(p, o, d, c);
        #2;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_top", top, 32'h0);

        op(1, 0, 32'hA, 0);
        op(1, 0, 32'hB, 0);
        op(1, 0, 32'hC, 0);
        chk("abc_top", top, 32'hC);
        chk("abc_next", next, 32'hB);
        chk("abc_count", 32'(count), 32'h3);
        chk("abc_empty", 32'(empty), 32'h0);

        op(0, 1, 0, 0);
        chk("pop1_top", top, 32'hB);
        chk("pop1_next", next, 32'hA);
        op(0, 1, 0, 0);
        chk("pop2_top", top, 32'hA);
        chk("pop2_next", next, 32'h0);
        op(0, 1, 0, 0);
        chk("pop3_top", top, 32'h0);
        chk("pop3_empty", 32'(empty), 32'h1);
        chk("pop3_flags", 32'({overflow, underflow}), 32'h0);

        for (int i = 1; i <= DEPTH; i++) op(1, 0, 32'(i * 'h11), 0);
        chk("fill_full", 32'(full), 32'h1);
        op(1, 0, 32'hFF, 0);
        chk("ovf_set", 32'(overflow), 32'h1);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_top", top, 32'h110);
        op(0, 0, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'h0);
        op(1, 0, 32'hFF, 1);
        chk("ovf_clr_vs_err", 32'(overflow), 32'h1);
        op(1, 1, 32'hEE, 0);
        chk("full_replace_top", top, 32'hEE);
        op(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) op(0, 1, 0, 0);

        op(0, 1, 0, 0);
        chk("unf_set", 32'(underflow), 32'h1);
        op(1, 1, 32'h5, 0);
        chk("pp_empty_count", 32'(count), 32'h1);
        chk("pp_empty_top", top, 32'h5);
        chk("pp_empty_unf", 32'(underflow), 32'h1);
        op(0, 1, 0, 1);
        chk("unf_clr", 32'(underflow), 32'h0);

        op(1, 0, 32'h1, 0);
        op(1, 0, 32'h2, 0);
        op(1, 1, 32'h9, 0);
        chk("pp2_top", top, 32'h9);
        chk("pp2_next", next, 32'h1);
        chk("pp2_count", 32'(count), 32'h2);
        op(1, 0, 32'h3, 0);
        op(1, 1, 32'h7, 0);
        op(1, 0, 32'h4, 0);
        op(0, 1, 0, 0);
        chk("mem_replace_top", top, 32'h7);
        chk("mem_replace_next", next, 32'h9);
        op(0, 1, 0, 0);
        op(0, 1, 0, 0);
        chk("deep_pop_top", top, 32'h1);

        // Reset pulse between edges while a push is being driven
        push      = 1'b1;
        push_data = 32'h77;
        #1 reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(count), 32'h0);
        chk("arst_top", top, 32'h0);
        chk("arst_next", next, 32'h0);
        chk("arst_empty", 32'(empty), 32'h1);
        chk("arst_flags", 32'({full, overflow, underflow}), 32'h0);
        #1 reset_n = 1'b1;
        push = 1'b0;
        @(posedge clk);
        #2;
        chk("arst_after_count", 32'(count), 32'h0);
        op(1, 0, 32'h42, 0);
        chk("arst_first_push", top, 32'h42);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
